regfile_sb: RTL and testbench

Parametrised successor to the processor's register file: DEPTH×WIDTH storage with three combinational read ports (Rn, Rm, Ra for multiply-accumulate) and two synchronous write ports (low and high product). Adds a post-reset hardware clear sweep, a selectable write-to-read bypass, and a per-register scoreboard so the multi-cycle control unit can reserve a destination before issue and stall dependent reads until writeback. The PC index is never stored; it reads the externally supplied PC value.

---
 rtl/regfile_sb.sv | 210 +++++++++++++++++++++
 tb/tb_regfile_sb.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// -----------------------------------------------------------------------------
// regfile_sb -- DEPTH x WIDTH register file with scoreboard and clear sweep.
//
// Three combinational read ports (Rn, Rm, Ra) and two synchronous write ports
// (port 3: Rd / low product, port 4: Ra / high product). After reset the file
// zeroes itself one register per cycle (CLEAR). Once the sweep finishes it
// enters RUN and raises `ready`. A per-register pending bit lets the control
// unit reserve a destination before issue. Reads of a pending register raise
// busyN until writeback. The PC index is never stored; reads of it return the
// externally supplied `r15`.
//
// Parameters
//   WIDTH   data width
//   DEPTH   register count (power of two, >= 4)
//   AW      address width, derived from DEPTH
//   PC_IDX  index that maps to the external r15 value
//   BYPASS  1: a read of an address written this cycle returns the write data
//
// Ports
//   clk, reset           clock, synchronous active-high reset
//   ra1..ra3 / rd1..rd3  read addresses / combinational read data
//   busy1..busy3         pending bit of the addressed register
//   we3, wa3, wd3        write port 3
//   we4, wa4, wd4        write port 4 (wins on an address collision)
//   rsv, rsv_addr        reserve request: mark rsv_addr pending
//   r15                  value returned for reads of PC_IDX
//   ready                1 once the clear sweep has completed
//
// Handshake: there is no valid/ready pair on the data path. `ready` is a level
// that qualifies every port: while it is low, writes and reserves are ignored
// and all read/busy outputs are held at 0. busyN is a level meaning "the value
// on rdN is stale; a reserved producer has not written back yet".
//
// Debug: the FSM state is held in the internal signal `state` (state_t), and
// the sweep position in `idx`, both available for checker binding.
// -----------------------------------------------------------------------------
module regfile_sb #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH),
  parameter int PC_IDX = DEPTH - 1,
  parameter bit BYPASS = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AW-1:0]    ra1,
  input  logic [AW-1:0]    ra2,
  input  logic [AW-1:0]    ra3,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2,
  output logic [WIDTH-1:0] rd3,
  output logic             busy1,
  output logic             busy2,
  output logic             busy3,
  input  logic             we3,
  input  logic [AW-1:0]    wa3,
  input  logic [WIDTH-1:0] wd3,
  input  logic             we4,
  input  logic [AW-1:0]    wa4,
  input  logic [WIDTH-1:0] wd4,
  input  logic             rsv,
  input  logic [AW-1:0]    rsv_addr,
  input  logic [WIDTH-1:0] r15,
  output logic             ready
);

  localparam logic [AW-1:0] PC_A = AW'(PC_IDX);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [AW-1:0]    idx;
  logic [AW-1:0]    idx_nxt;
  logic [DEPTH-1:0] pending;
  logic [DEPTH-1:0] pending_nxt;
  logic [WIDTH-1:0] regs [DEPTH];

  // Architectural write strobes. Writes to the PC slot never reach storage,
  // and nothing is written outside RUN.
  logic wr3;
  logic wr4;
  logic rsv_ok;

  always_comb begin
    wr3    = (state == RUN) && we3 && (wa3 != PC_A);
    wr4    = (state == RUN) && we4 && (wa4 != PC_A);
    rsv_ok = (state == RUN) && rsv && (rsv_addr != PC_A);
  end

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= CLEAR;
      idx     <= '0;
      pending <= '0;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      pending <= pending_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next-state, scoreboard update and ready
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    pending_nxt = pending;
    ready       = 1'b0;
    case (state)
      CLEAR: begin
        // One register zeroed per cycle; the edge that writes the last slot
        // also moves to RUN. idx wraps back to 0, which is harmless.
        idx_nxt = idx + 1'b1;
        if (idx == LAST) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        ready = 1'b1;
        // Writeback clears, then a reservation sets, so a reserve that
        // coincides with a write to the same register leaves it pending:
        // the newly issued producer owns the destination.
        if (wr3) begin
          pending_nxt[wa3] = 1'b0;
        end
        if (wr4) begin
          pending_nxt[wa4] = 1'b0;
        end
        if (rsv_ok) begin
          pending_nxt[rsv_addr] = 1'b1;
        end
      end
      default: begin
        state_nxt = CLEAR;
        idx_nxt   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Storage. No reset on the array itself: the sweep zeroes it instead.
  // Port 4 is written last so it wins when both ports target one register.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == CLEAR) begin
        regs[idx] <= '0;
      end else begin
        if (wr3) begin
          regs[wa3] <= wd3;
        end
        if (wr4) begin
          regs[wa4] <= wd4;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports
  // ---------------------------------------------------------------------------
  // PC wins over the bypass, and port 4 wins over port 3 in the bypass, which
  // mirrors what storage will hold after the edge.
  function automatic logic [WIDTH-1:0] read_data(input logic [AW-1:0] a);
    logic [WIDTH-1:0] v;
    v = '0;
    if (state == RUN) begin
      if (a == PC_A) begin
        v = r15;
      end else if (BYPASS && we4 && (wa4 == a)) begin
        v = wd4;
      end else if (BYPASS && we3 && (wa3 == a)) begin
        v = wd3;
      end else begin
        v = regs[a];
      end
    end
    return v;
  endfunction

  // busy has no bypass: a writeback clears pending at the edge, so busy
  // falls the cycle after the write.
  function automatic logic read_busy(input logic [AW-1:0] a);
    logic b;
    b = 1'b0;
    if ((state == RUN) && (a != PC_A)) begin
      b = pending[a];
    end
    return b;
  endfunction

  always_comb begin
    rd1   = read_data(ra1);
    rd2   = read_data(ra2);
    rd3   = read_data(ra3);
    busy1 = read_busy(ra1);
    busy2 = read_busy(ra2);
    busy3 = read_busy(ra3);
  end

endmodule

// File: tb/tb_regfile_sb.sv
// -----------------------------------------------------------------------------
// tb_regfile_sb -- self-checking bench for regfile_sb.
//
// Three instances: dut_a (defaults, BYPASS=1), dut_b (BYPASS=0, same stimulus
// as dut_a) and dut_c (WIDTH=64, DEPTH=32). The driver sets inputs #1 after a
// rising edge and pushes the hand-computed expected outputs for that cycle
// into a queue; the monitor pops and compares them on the falling edge.
// -----------------------------------------------------------------------------
module tb_regfile_sb;

  localparam int W   = 32;
  localparam int AW  = 4;
  localparam int WC  = 64;
  localparam int AWC = 5;

  // Output selectors: base codes per instance plus offset per output.
  localparam int RD1 = 0, RD2 = 1, RD3 = 2, BSY1 = 3, BSY2 = 4, BSY3 = 5, RDY = 6;
  localparam int OA = 0, OB = 7, OC = 14;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic reset_c;

  // Shared stimulus for dut_a / dut_b
  logic [AW-1:0] ra1, ra2, ra3, wa3, wa4, rsv_addr;
  logic [W-1:0]  wd3, wd4, r15;
  logic          we3, we4, rsv;

  logic [W-1:0]  rd1_a, rd2_a, rd3_a, rd1_b, rd2_b, rd3_b;
  logic          busy1_a, busy2_a, busy3_a, ready_a;
  logic          busy1_b, busy2_b, busy3_b, ready_b;

  // Stimulus for dut_c
  logic [AWC-1:0] ra1_c, ra2_c, ra3_c, wa3_c, wa4_c, rsv_addr_c;
  logic [WC-1:0]  wd3_c, wd4_c, r15_c;
  logic           we3_c, we4_c, rsv_c;
  logic [WC-1:0]  rd1_c, rd2_c, rd3_c;
  logic           busy1_c, busy2_c, busy3_c, ready_c;

  regfile_sb dut_a (
    .clk(clk), .reset(reset),
    .ra1(ra1), .ra2(ra2), .ra3(ra3),
    .rd1(rd1_a), .rd2(rd2_a), .rd3(rd3_a),
    .busy1(busy1_a), .busy2(busy2_a), .busy3(busy3_a),
    .we3(we3), .wa3(wa3), .wd3(wd3),
    .we4(we4), .wa4(wa4), .wd4(wd4),
    .rsv(rsv), .rsv_addr(rsv_addr), .r15(r15), .ready(ready_a)
  );

  regfile_sb #(.BYPASS(1'b0)) dut_b (
    .clk(clk), .reset(reset),
    .ra1(ra1), .ra2(ra2), .ra3(ra3),
    .rd1(rd1_b), .rd2(rd2_b), .rd3(rd3_b),
    .busy1(busy1_b), .busy2(busy2_b), .busy3(busy3_b),
    .we3(we3), .wa3(wa3), .wd3(wd3),
    .we4(we4), .wa4(wa4), .wd4(wd4),
    .rsv(rsv), .rsv_addr(rsv_addr), .r15(r15), .ready(ready_b)
  );

  regfile_sb #(.WIDTH(64), .DEPTH(32)) dut_c (
    .clk(clk), .reset(reset_c),
    .ra1(ra1_c), .ra2(ra2_c), .ra3(ra3_c),
    .rd1(rd1_c), .rd2(rd2_c), .rd3(rd3_c),
    .busy1(busy1_c), .busy2(busy2_c), .busy3(busy3_c),
    .we3(we3_c), .wa3(wa3_c), .wd3(wd3_c),
    .we4(we4_c), .wa4(wa4_c), .wd4(wd4_c),
    .rsv(rsv_c), .rsv_addr(rsv_addr_c), .r15(r15_c), .ready(ready_c)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [WC-1:0] exp_q [$];
  int            sel_q [$];
  int            cyc_q [$];
  string         name_q[$];

  int cyc      = 0;
  int checks   = 0;
  int failures = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic logic [WC-1:0] get_out(input int sel);
    logic [WC-1:0] v;
    case (sel)
      OA + RD1:  v = {32'h0, rd1_a};
      OA + RD2:  v = {32'h0, rd2_a};
      OA + RD3:  v = {32'h0, rd3_a};
      OA + BSY1: v = {63'h0, busy1_a};
      OA + BSY2: v = {63'h0, busy2_a};
      OA + BSY3: v = {63'h0, busy3_a};
      OA + RDY:  v = {63'h0, ready_a};
      OB + RD1:  v = {32'h0, rd1_b};
      OB + RD2:  v = {32'h0, rd2_b};
      OB + RD3:  v = {32'h0, rd3_b};
      OB + BSY1: v = {63'h0, busy1_b};
      OB + BSY2: v = {63'h0, busy2_b};
      OB + BSY3: v = {63'h0, busy3_b};
      OB + RDY:  v = {63'h0, ready_b};
      OC + RD1:  v = rd1_c;
      OC + RD2:  v = rd2_c;
      OC + RD3:  v = rd3_c;
      OC + BSY1: v = {63'h0, busy1_c};
      OC + BSY2: v = {63'h0, busy2_c};
      OC + BSY3: v = {63'h0, busy3_c};
      OC + RDY:  v = {63'h0, ready_c};
      default:   v = 'x;
    endcase
    return v;
  endfunction

  task automatic exp_push(input int sel, input logic [WC-1:0] val, input string name);
    exp_q.push_back(val);
    sel_q.push_back(sel);
    cyc_q.push_back(cyc);
    name_q.push_back(name);
  endtask

  // Monitor: outputs are combinational, so every cycle is an output event;
  // compare everything queued for the current cycle on the falling edge.
  initial forever begin
    @(negedge clk);
    while (cyc_q.size() > 0 && cyc_q[0] <= cyc) begin
      logic [WC-1:0] e, a;
      int            s, c;
      string         n;
      e = exp_q.pop_front();
      s = sel_q.pop_front();
      c = cyc_q.pop_front();
      n = name_q.pop_front();
      a = get_out(s);
      checks++;
      if (c != cyc) begin
        failures++;
        $display("FAIL %s: expectation for cycle %0d was not sampled in time (now %0d)", n, c, cyc);
      end else if (a !== e) begin
        failures++;
        $display("FAIL %s: cycle %0d got 0x%0h expected 0x%0h", n, cyc, a, e);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we3 = 1'b0;
    we4 = 1'b0;
    rsv = 1'b0;
  endtask

  task automatic idle_c();
    we3_c = 1'b0;
    we4_c = 1'b0;
    rsv_c = 1'b0;
  endtask

  task automatic finish_report();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  // Watchdog: the run is a fixed ~150 cycles, so this only fires on a bench bug.
  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    finish_report();
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int pc_list [7];

    reset = 1'b1; reset_c = 1'b1;
    ra1 = '0; ra2 = '0; ra3 = '0; wa3 = '0; wa4 = '0; rsv_addr = '0;
    wd3 = '0; wd4 = '0; r15 = 32'h0000_1000;
    idle();
    ra1_c = '0; ra2_c = '0; ra3_c = '0; wa3_c = '0; wa4_c = '0; rsv_addr_c = '0;
    wd3_c = '0; wd4_c = '0; r15_c = 64'hFEDC_BA98_7654_3210;
    idle_c();

    // Reset for one edge, then 16 sweep cycles with ready low.
    step();
    reset = 1'b0;
    for (int k = 0; k < 16; k++) begin
      ra1 = AW'(15 - k);
      ra2 = AW'(k);
      exp_push(OA + RDY,  64'h0, "sweep_ready_a");
      exp_push(OB + RDY,  64'h0, "sweep_ready_b");
      exp_push(OA + RD1,  64'h0, "sweep_rd1");
      exp_push(OA + RD2,  64'h0, "sweep_rd2");
      exp_push(OA + BSY1, 64'h0, "sweep_busy1");
      step();
    end
    ra1 = 4'd15;
    exp_push(OA + RDY, 64'h1, "run_ready_a");
    exp_push(OB + RDY, 64'h1, "run_ready_b");
    exp_push(OA + RD1, 64'h1000, "run_pc_read");
    step();
    for (int a = 0; a < 15; a++) begin
      ra1 = AW'(a);
      exp_push(OA + RD1,  64'h0, "post_clear_rd1");
      exp_push(OA + BSY1, 64'h0, "post_clear_busy1");
      step();
    end

    // Write bypass on port 3.
    we3 = 1'b1; wa3 = 4'd2; wd3 = 32'hDEAD_BEEF; ra1 = 4'd2;
    exp_push(OA + RD1, 64'hDEAD_BEEF, "bypass_wr3_a");
    exp_push(OB + RD1, 64'h0,         "nobypass_wr3_b");
    step();
    idle();
    exp_push(OA + RD1, 64'hDEAD_BEEF, "stored_wr3_a");
    exp_push(OB + RD1, 64'hDEAD_BEEF, "stored_wr3_b");
    step();

    // Both ports to one address: port 4 wins, in bypass and in storage.
    we3 = 1'b1; wa3 = 4'd5; wd3 = 32'h1111_1111;
    we4 = 1'b1; wa4 = 4'd5; wd4 = 32'h2222_2222; ra1 = 4'd5;
    exp_push(OA + RD1, 64'h2222_2222, "collide_bypass_a");
    exp_push(OB + RD1, 64'h0,         "collide_old_b");
    step();
    idle();
    exp_push(OA + RD1, 64'h2222_2222, "collide_stored_a");
    exp_push(OB + RD1, 64'h2222_2222, "collide_stored_b");
    step();

    // Write to PC index is dropped; reads follow r15.
    we3 = 1'b1; wa3 = 4'd15; wd3 = 32'hFFFF_FFFF; ra1 = 4'd15;
    exp_push(OA + RD1, 64'h1000, "pc_write_same_a");
    exp_push(OB + RD1, 64'h1000, "pc_write_same_b");
    step();
    idle();
    r15 = 32'h0000_2000; ra3 = 4'd15;
    exp_push(OA + RD1,  64'h2000, "pc_after_write_rd1");
    exp_push(OA + RD3,  64'h2000, "pc_rd3_a");
    exp_push(OB + RD3,  64'h2000, "pc_rd3_b");
    exp_push(OA + BSY3, 64'h0,    "pc_busy3");
    step();

    // Scoreboard: reserve, writeback, reserve racing a write.
    rsv = 1'b1; rsv_addr = 4'd7; ra2 = 4'd7;
    exp_push(OA + BSY2, 64'h0, "rsv_latency_busy2");
    exp_push(OA + RD2,  64'h0, "rsv_rd2");
    step();
    idle();
    exp_push(OA + BSY2, 64'h1, "rsv_busy2_a");
    exp_push(OB + BSY2, 64'h1, "rsv_busy2_b");
    step();
    we4 = 1'b1; wa4 = 4'd7; wd4 = 32'hCAFE_0000;
    exp_push(OA + BSY2, 64'h1,         "wb_busy2_same_cycle");
    exp_push(OA + RD2,  64'hCAFE_0000, "wb_rd2_bypass_a");
    exp_push(OB + RD2,  64'h0,         "wb_rd2_old_b");
    step();
    idle();
    exp_push(OA + BSY2, 64'h0,         "wb_busy2_cleared_a");
    exp_push(OB + BSY2, 64'h0,         "wb_busy2_cleared_b");
    exp_push(OA + RD2,  64'hCAFE_0000, "wb_rd2_stored_a");
    exp_push(OB + RD2,  64'hCAFE_0000, "wb_rd2_stored_b");
    step();
    rsv = 1'b1; rsv_addr = 4'd7; we3 = 1'b1; wa3 = 4'd7; wd3 = 32'h7777_7777;
    exp_push(OA + BSY2, 64'h0, "race_busy2_before");
    step();
    idle();
    exp_push(OA + BSY2, 64'h1,         "race_busy2_after_a");
    exp_push(OB + BSY2, 64'h1,         "race_busy2_after_b");
    exp_push(OA + RD2,  64'h7777_7777, "race_rd2_written");
    step();

    // Reserve 3 and 9, then reset mid-RUN.
    rsv = 1'b1; rsv_addr = 4'd3;
    step();
    rsv_addr = 4'd9;
    step();
    idle();
    ra1 = 4'd3; ra3 = 4'd9;
    exp_push(OA + BSY1, 64'h1, "pre_reset_busy1");
    exp_push(OA + BSY3, 64'h1, "pre_reset_busy3");
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    ra2 = 4'd2;
    for (int k = 0; k < 16; k++) begin
      we3 = 1'b1; wa3 = 4'd4; wd3 = 32'hAAAA_5555;
      we4 = 1'b1; wa4 = 4'd6; wd4 = 32'h0000_0066;
      rsv = 1'b1; rsv_addr = 4'd4;
      exp_push(OA + RDY,  64'h0, "resweep_ready");
      exp_push(OA + BSY1, 64'h0, "resweep_busy1");
      exp_push(OA + BSY3, 64'h0, "resweep_busy3");
      exp_push(OA + RD2,  64'h0, "resweep_rd2");
      step();
    end
    idle();
    pc_list = '{2, 3, 4, 5, 6, 7, 9};
    for (int i = 0; i < 7; i++) begin
      ra1 = AW'(pc_list[i]);
      ra2 = AW'(pc_list[i]);
      exp_push(OA + RDY,  64'h1, "resweep_done_ready");
      exp_push(OA + RD1,  64'h0, "resweep_zeroed_a");
      exp_push(OB + RD1,  64'h0, "resweep_zeroed_b");
      exp_push(OA + BSY2, 64'h0, "resweep_pending_clear");
      step();
    end

    // Wide/deep instance: 32-cycle sweep, PC at 31, 64-bit round trip.
    reset_c = 1'b0;
    ra1_c = 5'd31;
    for (int k = 0; k < 32; k++) begin
      exp_push(OC + RDY, 64'h0, "c_sweep_ready");
      exp_push(OC + RD1, 64'h0, "c_sweep_rd1");
      step();
    end
    exp_push(OC + RDY, 64'h1, "c_run_ready");
    exp_push(OC + RD1, 64'hFEDC_BA98_7654_3210, "c_pc_read");
    step();
    we3_c = 1'b1; wa3_c = 5'd30; wd3_c = 64'h0123_4567_89AB_CDEF; ra2_c = 5'd30;
    exp_push(OC + RD2, 64'h0123_4567_89AB_CDEF, "c_bypass_rd2");
    step();
    idle_c();
    ra1_c = 5'd30; ra3_c = 5'd29;
    exp_push(OC + RD1,  64'h0123_4567_89AB_CDEF, "c_stored_rd1");
    exp_push(OC + RD3,  64'h0, "c_rd3_other");
    exp_push(OC + BSY1, 64'h0, "c_busy1");
    step();

    step();
    step();
    if (cyc_q.size() != 0) begin
      failures += cyc_q.size();
      $display("FAIL leftover: %0d expectations never compared", cyc_q.size());
    end
    finish_report();
  end

endmodule
